// File: rtl/ik_frame_sequencer.sv
// Frame sequencer for the per-leg inverse-kinematics pipelines.
// Accepts a setpoint, broadcasts it, then runs stage1 and stage2 on every leg
// in lockstep while gathering per-leg valids. Each stage has a watchdog. An
// update-rate holdoff spaces out accepted setpoints, and abort cancels a frame.
module ik_frame_sequencer #(
    parameter int NUM_LEGS      = 3,
    parameter int TIMEOUT       = 256,
    parameter int UPDATE_PERIOD = 1000000
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                sp_valid,
    output logic                sp_ready,
    input  logic [8:0]          sp_lx,
    input  logic [8:0]          sp_ly,
    input  logic [7:0]          sp_lz,
    output logic [8:0]          lx,
    output logic [8:0]          ly,
    output logic [7:0]          lz,
    output logic                stage_rst,
    output logic                s1_enable,
    input  logic [NUM_LEGS-1:0] s1_valid,
    output logic                s2_enable,
    input  logic [NUM_LEGS-1:0] s2_valid,
    input  logic                abort,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout_err
);

    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam int HOW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [HOW-1:0] HOLD_LOAD = (UPDATE_PERIOD > 1) ? HOW'(UPDATE_PERIOD - 1) : '0;
    localparam logic [NUM_LEGS-1:0] ALL_LEGS = {NUM_LEGS{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_S1,
        ST_S2,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [8:0]          lx_q, lx_d;
    logic [8:0]          ly_q, ly_d;
    logic [7:0]          lz_q, lz_d;
    logic [NUM_LEGS-1:0] mask1_q, mask1_d;
    logic [NUM_LEGS-1:0] mask2_q, mask2_d;
    logic [WDW-1:0]      wd_q, wd_d;
    logic [HOW-1:0]      hold_q, hold_d;
    logic                terr_q, terr_d;
    logic                abort_rst;

    // Registered copies of the Moore outputs, computed from the next state
    logic sp_ready_q, sp_ready_d;
    logic stage_rst_q, stage_rst_d;
    logic s1_enable_q, s1_enable_d;
    logic s2_enable_q, s2_enable_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;

    logic [NUM_LEGS-1:0] mask1_acc;
    logic [NUM_LEGS-1:0] mask2_acc;

    assign mask1_acc = mask1_q | s1_valid;
    assign mask2_acc = mask2_q | s2_valid;

    // Next-state, datapath and output decode for the whole frame controller
    always_comb begin
        state_d   = state_q;
        lx_d      = lx_q;
        ly_d      = ly_q;
        lz_d      = lz_q;
        mask1_d   = mask1_q;
        mask2_d   = mask2_q;
        wd_d      = wd_q;
        hold_d    = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
        terr_d    = terr_q;
        abort_rst = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sp_valid && (hold_q == '0)) begin
                    lx_d    = sp_lx;
                    ly_d    = sp_ly;
                    lz_d    = sp_lz;
                    hold_d  = HOLD_LOAD;
                    terr_d  = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mask1_d = '0;
                mask2_d = '0;
                wd_d    = '0;
                if (abort) begin
                    abort_rst = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_S1;
                end
            end
            ST_S1: begin
                mask1_d = mask1_acc;
                if (abort) begin
                    abort_rst = 1'b1;
                    state_d   = ST_IDLE;
                end else if (mask1_acc == ALL_LEGS) begin
                    wd_d    = '0;
                    state_d = ST_S2;
                end else if (wd_q == WD_LAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_S2: begin
                mask2_d = mask2_acc;
                if (abort) begin
                    abort_rst = 1'b1;
                    state_d   = ST_IDLE;
                end else if (mask2_acc == ALL_LEGS) begin
                    state_d = ST_DONE;
                end else if (wd_q == WD_LAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        sp_ready_d   = (state_d == ST_IDLE) && (hold_d == '0);
        stage_rst_d  = (state_d == ST_CLEAR) || (state_d == ST_ERR) || abort_rst;
        s1_enable_d  = (state_d == ST_S1) && (state_q != ST_S1);
        s2_enable_d  = (state_d == ST_S2) && (state_q != ST_S2);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
    end

    // State, latched setpoint, masks, counters and registered outputs
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lx_q         <= '0;
            ly_q         <= '0;
            lz_q         <= '0;
            mask1_q      <= '0;
            mask2_q      <= '0;
            wd_q         <= '0;
            hold_q       <= '0;
            terr_q       <= 1'b0;
            sp_ready_q   <= 1'b1;
            stage_rst_q  <= 1'b0;
            s1_enable_q  <= 1'b0;
            s2_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lx_q         <= lx_d;
            ly_q         <= ly_d;
            lz_q         <= lz_d;
            mask1_q      <= mask1_d;
            mask2_q      <= mask2_d;
            wd_q         <= wd_d;
            hold_q       <= hold_d;
            terr_q       <= terr_d;
            sp_ready_q   <= sp_ready_d;
            stage_rst_q  <= stage_rst_d;
            s1_enable_q  <= s1_enable_d;
            s2_enable_q  <= s2_enable_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sp_ready    = sp_ready_q;
    assign lx          = lx_q;
    assign ly          = ly_q;
    assign lz          = lz_q;
    assign stage_rst   = stage_rst_q;
    assign s1_enable   = s1_enable_q;
    assign s2_enable   = s2_enable_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_ik_frame_sequencer.sv
// Directed testbench for ik_frame_sequencer (3 legs, timeout 16, period 20).
module tb_ik_frame_sequencer;

    logic       clock;
    logic       rst_n;
    logic       sp_valid;
    logic       sp_ready;
    logic [8:0] sp_lx;
    logic [8:0] sp_ly;
    logic [7:0] sp_lz;
    logic [8:0] lx;
    logic [8:0] ly;
    logic [7:0] lz;
    logic       stage_rst;
    logic       s1_enable;
    logic [2:0] s1_valid;
    logic       s2_enable;
    logic [2:0] s2_valid;
    logic       abort;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    ik_frame_sequencer #(
        .NUM_LEGS(3),
        .TIMEOUT(16),
        .UPDATE_PERIOD(20)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .sp_valid(sp_valid),
        .sp_ready(sp_ready),
        .sp_lx(sp_lx),
        .sp_ly(sp_ly),
        .sp_lz(sp_lz),
        .lx(lx),
        .ly(ly),
        .lz(lz),
        .stage_rst(stage_rst),
        .s1_enable(s1_enable),
        .s1_valid(s1_valid),
        .s2_enable(s2_enable),
        .s2_valid(s2_valid),
        .abort(abort),
        .busy(busy),
        .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL global_time_limit obs=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (sp_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("wait_ready", sp_ready, 1);
    endtask

    // Accept a setpoint; returns observing the CLEAR cycle (t0+1)
    task automatic accept(input logic [8:0] x, input logic [8:0] y, input logic [7:0] z);
        wait_ready();
        sp_lx = x; sp_ly = y; sp_lz = z; sp_valid = 1'b1;
        tick();
        sp_valid = 1'b0; sp_lx = 9'h0AA; sp_ly = 9'h155; sp_lz = 8'h5A;
        $display("accept lx=%0h ly=%0h lz=%0h", x, y, z);
    endtask

    // Full frame with valids returned one cycle after each enable
    task automatic run_nominal(input logic [8:0] x, input logic [8:0] y, input logic [7:0] z);
        accept(x, y, z);
        chk("nom_clear_rst", stage_rst, 1);
        chk("nom_clear_busy", busy, 1);
        chk("nom_clear_ready", sp_ready, 0);
        chk("nom_clear_s1en", s1_enable, 0);
        chk("nom_clear_terr", timeout_err, 0);
        tick();
        chk("nom_s1en", s1_enable, 1);
        chk("nom_s1_rst", stage_rst, 0);
        tick();
        chk("nom_s1en_off", s1_enable, 0);
        s1_valid = 3'b111;
        tick();
        s1_valid = 3'b000;
        chk("nom_s2en", s2_enable, 1);
        tick();
        chk("nom_s2en_off", s2_enable, 0);
        chk("nom_no_done_early", frame_done, 0);
        s2_valid = 3'b111;
        tick();
        s2_valid = 3'b000;
        chk("nom_done", frame_done, 1);
        chk("nom_lx", lx, x);
        chk("nom_ly", ly, y);
        chk("nom_lz", lz, z);
        tick();
        chk("nom_done_off", frame_done, 0);
        chk("nom_idle_busy", busy, 0);
        chk("nom_holdoff_ready", sp_ready, 0);
        chk("nom_lx_hold", lx, x);
        $display("frame nominal complete");
    endtask

    initial begin
        int acc[$];
        int dn[$];
        rst_n = 1'b0; sp_valid = 1'b0; sp_lx = '0; sp_ly = '0; sp_lz = '0;
        s1_valid = '0; s2_valid = '0; abort = 1'b0;
        tick();
        tick();
        chk("rst_ready", sp_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_lx", lx, 0);
        chk("rst_stage_rst", stage_rst, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_terr", timeout_err, 0);
        rst_n = 1'b1;
        tick();
        $display("reset released");

        // Nominal: -24 -> 9'h1E8 (488), 26, 117
        run_nominal(9'd488, 9'd26, 8'd117);

        // Staggered one-cycle valid pulses, stray s2 bits during S1
        accept(9'd5, 9'd6, 8'd7);
        tick();
        chk("stag_s1en", s1_enable, 1);
        s1_valid = 3'b001;
        tick();
        chk("stag_wait1", s2_enable, 0);
        s1_valid = 3'b100; s2_valid = 3'b111;
        tick();
        chk("stag_wait2", s2_enable, 0);
        s1_valid = 3'b010; s2_valid = 3'b000;
        tick();
        s1_valid = 3'b000;
        chk("stag_s2en", s2_enable, 1);
        s2_valid = 3'b011;
        tick();
        chk("stag_stray_ignored", frame_done, 0);
        chk("stag_busy", busy, 1);
        s2_valid = 3'b100;
        tick();
        s2_valid = 3'b000;
        chk("stag_done", frame_done, 1);
        $display("frame staggered complete");

        // Timeout in S2 with leg 1 missing
        accept(9'd1, 9'd2, 8'd3);
        tick();
        s1_valid = 3'b111;
        tick();
        s1_valid = 3'b000;
        chk("to_s2en", s2_enable, 1);
        s2_valid = 3'b101;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_in_s2_terr", timeout_err, 0);
            chk("to_in_s2_done", frame_done, 0);
        end
        chk("to_still_busy", busy, 1);
        chk("to_no_rst_yet", stage_rst, 0);
        tick();
        chk("to_err_terr", timeout_err, 1);
        chk("to_err_rst", stage_rst, 1);
        chk("to_err_done", frame_done, 0);
        tick();
        s2_valid = 3'b000;
        chk("to_idle_busy", busy, 0);
        chk("to_idle_rst", stage_rst, 0);
        chk("to_sticky", timeout_err, 1);
        $display("frame timeout complete");

        // Rate limit with sp_valid and all valids held high
        wait_ready();
        sp_valid = 1'b1; sp_lx = 9'd9; sp_ly = 9'd8; sp_lz = 8'd7;
        s1_valid = 3'b111; s2_valid = 3'b111;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (stage_rst === 1'b1 && busy === 1'b1) begin
                acc.push_back(i);
                if (acc.size() == 1) chk("rate_terr_cleared", timeout_err, 0);
            end
            if (frame_done === 1'b1) dn.push_back(i);
            if (acc.size() == 1 && i == acc[0] + 10) begin
                chk("rate_idle_busy", busy, 0);
                chk("rate_idle_not_ready", sp_ready, 0);
            end
        end
        sp_valid = 1'b0; s1_valid = 3'b000; s2_valid = 3'b000;
        chk("rate_accepts", acc.size(), 3);
        chk("rate_dones", dn.size(), 3);
        if (acc.size() >= 3) begin
            chk("rate_gap1", acc[1] - acc[0], 20);
            chk("rate_gap2", acc[2] - acc[1], 20);
        end
        if (acc.size() >= 1 && dn.size() >= 1) chk("rate_latency", dn[0] - acc[0], 3);
        $display("rate limit accepts=%0d", acc.size());

        // Abort in S1 after one leg valid
        accept(9'd11, 9'd12, 8'd13);
        tick();
        chk("ab1_s1en", s1_enable, 1);
        s1_valid = 3'b001;
        tick();
        s1_valid = 3'b000; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab1_idle", busy, 0);
        chk("ab1_rst", stage_rst, 1);
        chk("ab1_done", frame_done, 0);
        tick();
        chk("ab1_rst_off", stage_rst, 0);
        chk("ab1_terr", timeout_err, 0);
        $display("frame abort s1 complete");

        // Abort coincident with final s2_valid
        accept(9'd21, 9'd22, 8'd23);
        tick();
        s1_valid = 3'b111;
        tick();
        s1_valid = 3'b000;
        chk("ab2_s2en", s2_enable, 1);
        s2_valid = 3'b011;
        tick();
        s2_valid = 3'b100; abort = 1'b1;
        tick();
        s2_valid = 3'b000; abort = 1'b0;
        chk("ab2_done", frame_done, 0);
        chk("ab2_idle", busy, 0);
        chk("ab2_rst", stage_rst, 1);
        tick();
        chk("ab2_done_later", frame_done, 0);
        $display("frame abort s2 complete");

        // Async reset in S2: -100 -> 412
        accept(9'd412, 9'd50, 8'd200);
        tick();
        s1_valid = 3'b111;
        tick();
        s1_valid = 3'b000;
        chk("rs_s2en", s2_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_ready", sp_ready, 1);
        chk("rs_lx", lx, 0);
        chk("rs_lz", lz, 0);
        chk("rs_stage_rst", stage_rst, 0);
        chk("rs_s2en_off", s2_enable, 0);
        tick();
        rst_n = 1'b1;
        tick();
        $display("async reset applied mid frame");
        run_nominal(9'd412, 9'd50, 8'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ik_frame_sequencer.md
Name: ik_frame_sequencer

Overview:
Frame-level controller for the per-leg inverse-kinematics datapath. It accepts a platform setpoint (lx, ly, lz) through a valid/ready handshake and latches it. It then broadcasts the setpoint to NUM_LEGS stage1 instances (one per leg BETA) and sequences stage1 then stage2 with one-cycle enables, gathering per-leg valids. A watchdog, an update-rate limiter and an abort path ensure that every servo frame completes, times out cleanly or is cancelled.

Parameters:
NUM_LEGS, 3, number of leg pipelines driven in parallel
TIMEOUT, 256, max cycles spent in one stage before error (must be >=2)
UPDATE_PERIOD, 1000000, min cycles between accepted setpoints (0 or 1 = no limit)

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sp_valid  in  1  setpoint offered
sp_ready  out  1  setpoint accepted when sp_valid&sp_ready at clock edge
sp_lx  in  9  signed setpoint x
sp_ly  in  9  signed setpoint y
sp_lz  in  8  unsigned setpoint z
lx  out  9  latched signed x to all stage1 instances
ly  out  9  latched signed y
lz  out  8  latched z
stage_rst  out  1  active-high synchronous clear to stage1/stage2 instances
s1_enable  out  1  one-cycle start to all stage1
s1_valid  in  NUM_LEGS  per-leg stage1 valid (level or pulse)
s2_enable  out  1  one-cycle start to all stage2
s2_valid  in  NUM_LEGS  per-leg stage2 valid (level or pulse)
abort  in  1  synchronous cancel of current frame
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse, frame completed
timeout_err  out  1  sticky; set on watchdog expiry, cleared on next accepted setpoint

Behaviour:
- Reset (rst_n=0, async): state IDLE; lx/ly/lz=0; masks=0; watchdog=0; holdoff=0. All outputs 0 except sp_ready, which is 1.
- Moore outputs decoded from the state register. sp_ready = (state==IDLE) && (holdoff==0).
- States: IDLE, CLEAR, S1, S2, DONE, ERR.
- IDLE: on accept edge t0, latch sp_*, load holdoff=UPDATE_PERIOD-1 (saturate at 0), clear timeout_err, go CLEAR.
- CLEAR (cycle t0+1): stage_rst=1; masks and watchdog cleared; go S1.
- S1: s1_enable=1 on the first S1 cycle only. Each cycle, mask1 |= s1_valid. Move to S2 on the cycle after the next-mask value is all ones; valids arriving on the same cycle count toward completion.
- S2: identical to S1 using s2_enable, s2_valid and mask2. All ones moves to DONE.
- Watchdog: reset on entering S1 and S2, increments each cycle in the stage. If it reaches TIMEOUT-1 without completion, go ERR. Completion and expiry on the same cycle: completion wins.
- DONE: frame_done=1 for exactly one cycle; go IDLE.
- ERR: timeout_err set, stage_rst=1 for one cycle; go IDLE. No frame_done.
- abort=1 in CLEAR/S1/S2: go IDLE next cycle, with stage_rst=1 on that abort cycle's successor (one cycle). No frame_done, timeout_err unchanged. abort ignored in IDLE/DONE/ERR.
- abort and completion on the same cycle: abort wins.
- Holdoff decrements every cycle in any state until 0, so accepted setpoints are >= UPDATE_PERIOD cycles apart. A new sp_valid during a frame is back-pressured, never dropped.
- lx/ly/lz are stable from CLEAR through DONE; they change only on accept.
- Valids seen in IDLE/CLEAR/DONE are ignored. Stray s2_valid bits in S1 are ignored.
- Min frame latency: accept t0 → s1_enable t0+2 → frame_done t0+6 when valids return one cycle after each enable.
- Async reset mid-frame returns to reset values immediately. No stage_rst pulse is generated.

Test Plan:
Bench params: NUM_LEGS=3, TIMEOUT=16, UPDATE_PERIOD=20.
- Nominal: offer lx=-24, ly=26, lz=117. Return all s1_valid and s2_valid one cycle after each enable → stage_rst at t0+1, s1_enable at t0+2, s2_enable at t0+4, frame_done at t0+6. lx/ly/lz hold -24/26/117.
- Staggered valids: s1_valid bits 001, 100, 010 pulsed on separate cycles, each bit one cycle only → s2_enable only after the third bit, one cycle later. Same-cycle all-ones arrival advances in one cycle.
- Timeout: withhold s2_valid[1] → ERR 16 cycles after entering S2, timeout_err=1, stage_rst pulse, no frame_done. The next accepted setpoint clears timeout_err.
- Rate limit: hold sp_valid high continuously → successive accepts exactly 20 cycles apart. sp_ready=0 in between, even while IDLE.
- Abort: assert abort in S1 after one leg valid → IDLE, one stage_rst pulse, no frame_done. Abort coincident with final s2_valid → no frame_done.
- Reset: drop rst_n in S2 → busy=0, sp_ready=1, outputs zero immediately. After release, a fresh setpoint completes normally.
